// File: rtl/daw_pkg.sv
// Shared recorder definitions: sector geometry, packer FSM state types, helpers.
package daw_pkg;

   localparam int unsigned SECTOR_BYTES = 512;

   typedef enum logic {W_FILL, W_PAD} pack_wstate_t;
   typedef enum logic {R_IDLE, R_STREAM} pack_rstate_t;

   // Number of set bank-full flags.
   function automatic logic [1:0] full_count(input logic [1:0] flags);
      return {1'b0, flags[0]} + {1'b0, flags[1]};
   endfunction

endpackage

// File: rtl/sector_bank_ram.sv
// Simple dual-port sector RAM: one write port, one registered read port.
module sector_bank_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port, one cycle latency.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sample_sector_packer.sv
// Packs sample bytes into ping-pong sector banks and streams full sectors out.
module sample_sector_packer #(
   parameter int unsigned          DATA_W       = 8,
   parameter int unsigned          SECTOR_BYTES = daw_pkg::SECTOR_BYTES,
   parameter logic [DATA_W-1:0]    PAD_BYTE     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              record_en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        sectors_ready,
   output logic              overrun,
   output logic [15:0]       drop_count
);
   import daw_pkg::*;

   localparam int unsigned        IDX_W   = $clog2(SECTOR_BYTES);
   localparam logic [IDX_W-1:0]   IDX_MAX = '1;

   pack_wstate_t      wstate, wstate_nxt;
   pack_rstate_t      rstate, rstate_nxt;
   logic              wbank, rbank;
   logic [IDX_W-1:0]  widx, oidx;
   logic [IDX_W:0]    ridx;
   logic [1:0]        full, full_set, full_clr;
   logic              rec_q, rec_prev, rec_fall;
   logic              wr_en, drop, mark_full;
   logic [DATA_W-1:0] wr_data;
   logic              issue, pop, rd_release, room, rd_pend;
   logic [1:0]        fill_lvl;
   logic              ov, sv;
   logic [DATA_W-1:0] od, sd, rdata;

   assign rec_fall = rec_prev & ~rec_q;
   assign full_set = mark_full  ? (wbank ? 2'b10 : 2'b01) : 2'b00;
   assign full_clr = rd_release ? (rbank ? 2'b10 : 2'b01) : 2'b00;

   sector_bank_ram #(.DATA_W(DATA_W), .ADDR_W(IDX_W + 1)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wbank, widx}),
      .wdata (wr_data),
      .re    (issue),
      .raddr ({rbank, ridx[IDX_W-1:0]}),
      .rdata (rdata)
   );

   // Next-state and strobes for both the fill side and the stream side.
   always_comb begin
      wstate_nxt = wstate;
      rstate_nxt = rstate;
      wr_en      = 1'b0;
      wr_data    = sample_in;
      drop       = 1'b0;
      mark_full  = 1'b0;
      issue      = 1'b0;
      pop        = ov & out_ready;
      rd_release = pop & (oidx == IDX_MAX);
      fill_lvl   = {1'b0, ov} + {1'b0, sv} + {1'b0, rd_pend};
      // A read issued now lands next cycle; it must fit in out + skid.
      room       = (fill_lvl - {1'b0, pop}) < 2'd2;
      unique case (wstate)
         W_FILL: begin
            if (rec_fall && widx != '0) begin
               wstate_nxt = W_PAD;
            end else if (sample_valid && record_en) begin
               if (full[wbank]) begin
                  drop = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  mark_full = (widx == IDX_MAX);
               end
            end
         end
         W_PAD: begin
            wr_data = PAD_BYTE;
            if (!full[wbank]) begin
               wr_en = 1'b1;
               if (widx == IDX_MAX) begin
                  mark_full  = 1'b1;
                  wstate_nxt = W_FILL;
               end
            end
         end
      endcase
      unique case (rstate)
         R_IDLE: begin
            if (full[rbank]) begin
               issue      = 1'b1;
               rstate_nxt = R_STREAM;
            end
         end
         R_STREAM: begin
            if (!ridx[IDX_W] && room) issue = 1'b1;
            if (rd_release) rstate_nxt = R_IDLE;
         end
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate <= W_FILL;
         rstate <= R_IDLE;
      end else begin
         wstate <= wstate_nxt;
         rstate <= rstate_nxt;
      end
   end

   // Write pointer, bank flags, record_en edge tracking and drop statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         widx          <= '0;
         wbank         <= 1'b0;
         full          <= '0;
         sectors_ready <= '0;
         rec_q         <= 1'b0;
         rec_prev      <= 1'b0;
         overrun       <= 1'b0;
         drop_count    <= '0;
      end else begin
         if (wr_en)     widx  <= widx + 1'b1;
         if (mark_full) wbank <= ~wbank;
         full          <= (full | full_set) & ~full_clr;
         sectors_ready <= full_count(full);
         rec_q         <= record_en;
         rec_prev      <= rec_q;
         if (drop) begin
            overrun <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 16'd1;
         end
      end
   end

   // Read pointers plus output/skid registers forming a 2-entry stream buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ridx    <= '0;
         oidx    <= '0;
         rbank   <= 1'b0;
         rd_pend <= 1'b0;
         ov      <= 1'b0;
         sv      <= 1'b0;
         od      <= '0;
         sd      <= '0;
      end else begin
         rd_pend <= issue;
         if (rd_release) begin
            ridx  <= '0;
            rbank <= ~rbank;
         end else if (issue) begin
            ridx <= ridx + 1'b1;
         end
         if (pop) oidx <= oidx + 1'b1;
         // Arriving RAM data goes to the output slot if it is free after this
         // edge, otherwise into the skid; a pop promotes the skid first.
         if (pop) begin
            if (sv) begin
               od <= sd;
               sv <= rd_pend;
               if (rd_pend) sd <= rdata;
            end else begin
               ov <= rd_pend;
               if (rd_pend) od <= rdata;
            end
         end else if (rd_pend) begin
            if (ov) begin
               sd <= rdata;
               sv <= 1'b1;
            end else begin
               od <= rdata;
               ov <= 1'b1;
            end
         end
      end
   end

   assign out_valid = ov;
   assign out_data  = od;
   assign out_last  = ov & (oidx == IDX_MAX);

endmodule

// File: tb/tb_sample_sector_packer.sv
// Directed self-checking bench for sample_sector_packer.
module tb_sample_sector_packer;

   localparam int unsigned SB = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic        record_en;
   logic        sample_valid;
   logic [7:0]  sample_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  sectors_ready;
   logic        overrun;
   logic [15:0] drop_count;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned ready_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random
   logic [8:0]  rx_q [$];         // {last, data} of each handshake
   logic [7:0]  exp_q [$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   always #5 clk = ~clk;

   sample_sector_packer #(.DATA_W(8), .SECTOR_BYTES(SB), .PAD_BYTE(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .record_en     (record_en),
      .sample_valid  (sample_valid),
      .sample_in     (sample_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .sectors_ready (sectors_ready),
      .overrun       (overrun),
      .drop_count    (drop_count)
   );

   // Output monitor: collects handshakes and checks the stream holds while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_vec++;
            assert (out_valid === 1'b1 && out_data === prev_data) else begin
               n_err++;
               $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h",
                      out_valid, out_data, prev_data);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) rx_q.push_back({out_last, out_data});
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
      end
   end

   function automatic logic [7:0] pat(input int unsigned kind, input int unsigned i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(i * 3);
         2:       return 8'hEE;
         3:       return 8'(i * 7 + 3);
         4:       return 8'(i) ^ 8'hA5;
         default: return 8'(i + 8'h11);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push(input int unsigned n, input int unsigned kind,
                       input int unsigned gap, input bit keep);
      for (int unsigned i = 0; i < n; i++) begin
         tick();
         sample_valid = 1'b1;
         sample_in    = pat(kind, i);
         if (keep) exp_q.push_back(pat(kind, i));
         for (int unsigned g = 0; g < gap; g++) begin
            tick();
            sample_valid = 1'b0;
         end
      end
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_rx(input int unsigned n, input int unsigned budget, input string tag);
      int unsigned c = 0;
      while (rx_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, rx_q.size(), n);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk({tag, "_data"}, rx_q[i][7:0], exp_q[i]);
         chk({tag, "_last"}, rx_q[i][8], (i % SB) == SB - 1);
      end
   endtask

   task automatic clear_q();
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned lat;
      rst = 1'b0; record_en = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ready", sectors_ready, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_drops", drop_count, 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      record_en = 1'b1;
      repeat (3) tick();

      // 1: one sector, ready held high
      ready_mode = 1;
      clear_q();
      push(SB, 0, 0, 1'b1);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 3) begin
         tick();
         lat++;
      end
      chk("t1_first_valid", out_valid, 1);
      wait_rx(SB, 2000, "t1_wait");
      check_stream("t1");
      repeat (3) tick();
      chk("t1_sectors_idle", sectors_ready, 0);
      chk("t1_valid_idle", out_valid, 0);

      // 2: both banks full, overrun drops
      ready_mode = 0;
      tick();
      clear_q();
      push(2 * SB, 1, 0, 1'b1);
      repeat (2000) tick();
      push(10, 2, 0, 1'b0);
      repeat (2) tick();
      chk("t2_sectors", sectors_ready, 2);
      chk("t2_overrun", overrun, 1);
      chk("t2_drops", drop_count, 10);
      chk("t2_stalled_valid", out_valid, 1);
      ready_mode = 1;
      wait_rx(2 * SB, 4000, "t2_wait");
      check_stream("t2");
      repeat (3) tick();
      chk("t2_sectors_drained", sectors_ready, 0);

      // 3: partial sector flushed with pad bytes; samples during pad ignored
      clear_q();
      push(100, 4, 0, 1'b1);
      record_en = 1'b0;
      for (int unsigned i = 100; i < SB; i++) exp_q.push_back(8'h00);
      repeat (4) tick();
      record_en = 1'b1;
      push(5, 2, 0, 1'b0);
      wait_rx(SB, 3000, "t3_wait");
      check_stream("t3");
      chk("t3_drops", drop_count, 10);

      // 6: falling edge with empty sector produces nothing
      repeat (5) tick();
      clear_q();
      record_en = 1'b0;
      repeat (20) tick();
      chk("t6_sectors", sectors_ready, 0);
      chk("t6_valid", out_valid, 0);
      chk("t6_rx", rx_q.size(), 0);
      record_en = 1'b1;
      repeat (3) tick();

      // 4: four sectors with random backpressure
      ready_mode = 2;
      clear_q();
      push(4 * SB, 3, 3, 1'b1);
      wait_rx(4 * SB, 6000, "t4_wait");
      check_stream("t4");
      chk("t4_drops", drop_count, 10);

      // 5: reset mid-stream, then a fresh sector
      ready_mode = 1;
      tick();
      clear_q();
      push(SB, 0, 0, 1'b0);
      wait_rx(200, 2000, "t5_wait200");
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_last", out_last, 0);
      chk("t5_rst_data", out_data, 0);
      chk("t5_rst_sectors", sectors_ready, 0);
      chk("t5_rst_overrun", overrun, 0);
      chk("t5_rst_drops", drop_count, 0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      clear_q();
      push(SB, 5, 0, 1'b1);
      wait_rx(SB, 2000, "t5_wait");
      check_stream("t5");
      repeat (3) tick();
      chk("t5_sectors_idle", sectors_ready, 0);
      chk("t5_overrun", overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
